// File: rtl/hsv2rgb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hsv2rgb_arbiter: round-robin share of one fixed-latency HSV->RGB converter
// between two streams, with credit-protected per-channel output FIFOs.
// Optional pop/stall statistics: define HSV2RGB_ARB_STATS_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module hsv2rgb_arbiter #(
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] in0_hsv,
  input  logic        in0_valid,
  output logic        in0_ready,
  input  logic [23:0] in1_hsv,
  input  logic        in1_valid,
  output logic        in1_ready,
  output logic        cvt_resetn,
  output logic [23:0] cvt_hsv,
  output logic        cvt_valid,
  input  logic [23:0] cvt_rgb,
  input  logic        cvt_rgb_valid,
  output logic [23:0] out0_rgb,
  output logic        out0_valid,
  input  logic        out0_ready,
  output logic [23:0] out1_rgb,
  output logic        out1_valid,
  input  logic        out1_ready,
`ifdef HSV2RGB_ARB_STATS_EN
  output logic [31:0] stat0_cnt,
  output logic [31:0] stat1_cnt,
  output logic [31:0] stat_stall,
`endif
  output logic        tag_err
);

  localparam int c_CW = $clog2(FIFO_DEPTH + 1);
  localparam int c_PW = $clog2(FIFO_DEPTH);

  logic [1:0]         w_valid, w_out_ready, w_credit_nz, w_elig, w_grant;
  logic [1:0]         w_push, w_pop, w_out_valid;
  logic [23:0]        w_out_rgb [2];
  logic [23:0]        w_sel_hsv;
  logic               w_tag_vld, w_tag_ch, w_wr;
  logic               last_grant_q, cvt_valid_q, cvt_ch_q, cvt_resetn_q, tag_err_q;
  logic [23:0]        cvt_hsv_q;
  logic [LATENCY-1:0] tag_vld_q, tag_ch_q;

  assign w_valid     = {in1_valid, in0_valid};
  assign w_out_ready = {out1_ready, out0_ready};
  assign w_elig      = w_valid & w_credit_nz;

  always_comb begin
    w_grant = w_elig;
    if (&w_elig) w_grant = last_grant_q ? 2'b01 : 2'b10;
  end

  assign w_sel_hsv = w_grant[1] ? in1_hsv : in0_hsv;
  assign in0_ready = w_grant[0];
  assign in1_ready = w_grant[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      cvt_valid_q  <= 1'b0;
      cvt_ch_q     <= 1'b0;
      cvt_hsv_q    <= '0;
      cvt_resetn_q <= 1'b0;
    end else begin
      cvt_resetn_q <= 1'b1;
      cvt_valid_q  <= |w_grant;
      cvt_ch_q     <= w_grant[1];
      if (|w_grant) begin
        last_grant_q <= w_grant[1];
        cvt_hsv_q    <= w_sel_hsv;
      end
    end
  end

  // Tag stage 0 trails cvt_valid by one edge, so the last stage lines up with cvt_rgb_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_vld_q <= '0;
      tag_ch_q  <= '0;
      tag_err_q <= 1'b0;
    end else begin
      tag_vld_q[0] <= cvt_valid_q;
      tag_ch_q[0]  <= cvt_ch_q;
      for (int k = 1; k < LATENCY; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_ch_q[k]  <= tag_ch_q[k-1];
      end
      if (cvt_rgb_valid ^ w_tag_vld) tag_err_q <= 1'b1;
    end
  end

  assign w_tag_vld = tag_vld_q[LATENCY-1];
  assign w_tag_ch  = tag_ch_q[LATENCY-1];
  assign w_wr      = cvt_rgb_valid & w_tag_vld;
  assign w_push    = {w_wr & w_tag_ch, w_wr & ~w_tag_ch};
  assign w_pop     = w_out_valid & w_out_ready;

  for (genvar c = 0; c < 2; c++) begin : g_chan
    logic [23:0]     mem_q [FIFO_DEPTH];
    logic [c_PW-1:0] wptr_q, rptr_q;
    logic [c_CW-1:0] count_q, credit_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wptr_q   <= '0;
        rptr_q   <= '0;
        count_q  <= '0;
        credit_q <= c_CW'(FIFO_DEPTH);
      end else begin
        if (w_push[c]) wptr_q <= wptr_q + 1'b1;
        if (w_pop[c])  rptr_q <= rptr_q + 1'b1;
        case ({w_push[c], w_pop[c]})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: ;
        endcase
        // A slot is reserved at issue time and released only when the consumer pops it.
        case ({w_grant[c], w_pop[c]})
          2'b10:   credit_q <= credit_q - 1'b1;
          2'b01:   credit_q <= credit_q + 1'b1;
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (w_push[c]) mem_q[wptr_q] <= cvt_rgb;
    end

    assign w_credit_nz[c] = (credit_q != '0);
    assign w_out_valid[c] = (count_q != '0);
    assign w_out_rgb[c]   = w_out_valid[c] ? mem_q[rptr_q] : 24'h0;
  end

  assign cvt_resetn = cvt_resetn_q;
  assign cvt_hsv    = cvt_hsv_q;
  assign cvt_valid  = cvt_valid_q;
  assign out0_rgb   = w_out_rgb[0];
  assign out0_valid = w_out_valid[0];
  assign out1_rgb   = w_out_rgb[1];
  assign out1_valid = w_out_valid[1];
  assign tag_err    = tag_err_q;

`ifdef HSV2RGB_ARB_STATS_EN
  logic [31:0] stat0_q, stat1_q, stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat0_q <= '0;
      stat1_q <= '0;
      stall_q <= '0;
    end else begin
      if (w_pop[0]) stat0_q <= stat0_q + 32'd1;
      if (w_pop[1]) stat1_q <= stat1_q + 32'd1;
      if (|(w_valid & ~w_credit_nz)) stall_q <= stall_q + 32'd1;
    end
  end

  assign stat0_cnt  = stat0_q;
  assign stat1_cnt  = stat1_q;
  assign stat_stall = stall_q;
`endif

endmodule
`default_nettype wire
